// File: rtl/binary_clock_pkg.sv
// Shared widths, calendar limits and pixel-map layout for the binary clock.
package binary_clock_pkg;

  localparam int SEC_PER_MIN = 60;
  localparam int MIN_PER_HR  = 60;
  localparam int HR_PER_DAY  = 24;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  // Bit offsets of each field in the flattened pixel vector.
  localparam int MIN_OFF  = 0;
  localparam int HR_OFF   = 6;
  localparam int PM_OFF   = 11;
  localparam int SEC_OFF  = 12;
  localparam int PIX_USED = 18;

  typedef struct packed {
    logic [HR_W-1:0]  hours;
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
  } tod_t;

  function automatic logic [HR_W-1:0] hour_12h(input logic [HR_W-1:0] h);
    if (h == '0)
      return HR_W'(12);
    else if (h > HR_W'(12))
      return h - HR_W'(12);
    else
      return h;
  endfunction

endpackage

// File: rtl/binary_clock_scan_mod_counter.sv
// Enable-driven modulo counter with synchronous load; carry is high on the
// enabled cycle that wraps MOD-1 back to 0.
module mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (en)
      count_reg <= (count_reg == LAST) ? '0 : count_reg + W'(1);
  end

  assign count = count_reg;
  assign carry = en && (count_reg == LAST);

endmodule

// File: rtl/binary_clock_scan.sv
// Time-of-day core (free-run prescaler or PPS-disciplined) with a set
// handshake, 12h/24h display and a multiplexed LED-matrix scanner.
module binary_clock_scan
  import binary_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1,
  parameter int PPS_TIMEOUT   = 200,
  parameter int SHOW_SECONDS  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps,
  input  logic             mode_12h,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [4:0]       set_hours,
  input  logic [5:0]       set_minutes,
  output logic             set_err,
  output logic [4:0]       hours_disp,
  output logic             pm,
  output logic [5:0]       minutes,
  output logic [5:0]       seconds,
  output logic             sec_tick,
  output logic             day_tick,
  output logic             pps_locked,
  output logic [ROWS-1:0]  rows,
  output logic [COLS-1:0]  cols
);

  localparam int SUB_W = $clog2(TICKS_PER_SEC);
  localparam int TO_W  = $clog2(PPS_TIMEOUT);
  localparam int SD_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = $clog2(ROWS);
  localparam int NPIX  = ROWS * COLS;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PPS_TIMEOUT - 1);

  logic pps_s1_reg, pps_s2_reg, pps_d_reg;
  logic set_ready_reg, set_err_reg, sec_tick_reg, day_tick_reg, locked_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [ROWS-1:0] rows_reg;
  logic [COLS-1:0] cols_reg;

  logic pps_edge, accept, set_bad, set_ok, timeout, sub_load, tick_next;
  logic sub_carry, sec_carry, min_carry, hr_carry, div_carry, row_carry;
  logic [SUB_W-1:0] subsec;
  logic [SD_W-1:0]  scan_div;
  logic [ROW_W-1:0] row;
  logic [HR_W-1:0]  hr_cnt;
  logic [MIN_W-1:0] min_cnt;
  logic [SEC_W-1:0] sec_cnt;
  tod_t tod;

  assign pps_edge = pps_s2_reg && !pps_d_reg;
  assign accept   = set_valid && set_ready_reg;
  assign set_bad  = (set_hours > 5'(HR_PER_DAY - 1)) || (set_minutes > 6'(MIN_PER_HR - 1));
  assign set_ok   = accept && !set_bad;
  assign timeout  = locked_reg && !pps_edge && (to_cnt_reg == TO_LAST);
  assign sub_load = pps_edge || set_ok || timeout;
  // An accepted set overrides any second advance due in the same cycle.
  assign tick_next = !set_ok && (pps_edge || (sub_carry && !locked_reg));

  mod_counter #(.W(SUB_W), .MOD(TICKS_PER_SEC)) u_subsec (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .load(sub_load), .load_val('0),
    .count(subsec), .carry(sub_carry)
  );

  mod_counter #(.W(SEC_W), .MOD(SEC_PER_MIN)) u_sec (
    .clk(clk), .rst_n(rst_n), .en(tick_next), .load(set_ok), .load_val('0),
    .count(sec_cnt), .carry(sec_carry)
  );

  mod_counter #(.W(MIN_W), .MOD(MIN_PER_HR)) u_min (
    .clk(clk), .rst_n(rst_n), .en(sec_carry), .load(set_ok), .load_val(set_minutes),
    .count(min_cnt), .carry(min_carry)
  );

  mod_counter #(.W(HR_W), .MOD(HR_PER_DAY)) u_hr (
    .clk(clk), .rst_n(rst_n), .en(min_carry), .load(set_ok), .load_val(set_hours),
    .count(hr_cnt), .carry(hr_carry)
  );

  mod_counter #(.W(SD_W), .MOD(SCAN_DIV)) u_scan_div (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .load(1'b0), .load_val('0),
    .count(scan_div), .carry(div_carry)
  );

  mod_counter #(.W(ROW_W), .MOD(ROWS)) u_row (
    .clk(clk), .rst_n(rst_n), .en(div_carry), .load(1'b0), .load_val('0),
    .count(row), .carry(row_carry)
  );

  assign tod = '{hours: hr_cnt, minutes: min_cnt, seconds: sec_cnt};

  assign hours_disp = mode_12h ? hour_12h(tod.hours) : tod.hours;
  assign pm         = (tod.hours >= HR_W'(12));
  assign minutes    = tod.minutes;
  assign seconds    = tod.seconds;

  logic [NPIX-1:0] pix;
  logic [COLS-1:0] row_pix [ROWS];

  genvar gi;
  generate
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      if (gi < HR_OFF) begin : g_min
        assign pix[gi] = tod.minutes[gi-MIN_OFF];
      end else if (gi < PM_OFF) begin : g_hr
        assign pix[gi] = hours_disp[gi-HR_OFF];
      end else if (gi == PM_OFF) begin : g_pm
        assign pix[gi] = pm;
      end else if ((SHOW_SECONDS != 0) && (gi < PIX_USED)) begin : g_sec
        assign pix[gi] = tod.seconds[gi-SEC_OFF];
      end else begin : g_zero
        assign pix[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_pix[gi] = pix[gi*COLS +: COLS];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pps_s1_reg    <= 1'b0;
      pps_s2_reg    <= 1'b0;
      pps_d_reg     <= 1'b0;
      set_ready_reg <= 1'b0;
      set_err_reg   <= 1'b0;
      sec_tick_reg  <= 1'b0;
      day_tick_reg  <= 1'b0;
      locked_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      rows_reg      <= '0;
      cols_reg      <= '0;
    end else begin
      pps_s1_reg    <= pps;
      pps_s2_reg    <= pps_s1_reg;
      pps_d_reg     <= pps_s2_reg;
      set_ready_reg <= !accept;
      set_err_reg   <= accept && set_bad;
      sec_tick_reg  <= tick_next;
      day_tick_reg  <= hr_carry;
      if (pps_edge) begin
        locked_reg <= 1'b1;
        to_cnt_reg <= '0;
      end else if (timeout) begin
        locked_reg <= 1'b0;
      end else if (locked_reg) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
      rows_reg <= ~(ROWS'(1) << row);
      cols_reg <= row_pix[row];
    end
  end

  assign set_ready  = set_ready_reg;
  assign set_err    = set_err_reg;
  assign sec_tick   = sec_tick_reg;
  assign day_tick   = day_tick_reg;
  assign pps_locked = locked_reg;
  assign rows       = rows_reg;
  assign cols       = cols_reg;

endmodule

// File: tb/tb_binary_clock_scan.sv
// Directed bench for binary_clock_scan with a 4-tick second and 20-cycle PPS timeout.
module tb_binary_clock_scan;

  logic       clk = 1'b0;
  logic       rst_n, pps, mode_12h, set_valid;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       set_ready, set_err, pm, sec_tick, day_tick, pps_locked;
  logic [4:0] hours_disp;
  logic [5:0] minutes, seconds;
  logic [3:0] rows, cols;

  int checks = 0;
  int errors = 0;

  binary_clock_scan #(
    .TICKS_PER_SEC(4), .ROWS(4), .COLS(4), .SCAN_DIV(1),
    .PPS_TIMEOUT(20), .SHOW_SECONDS(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pps(pps), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_ready(set_ready), .set_hours(set_hours),
    .set_minutes(set_minutes), .set_err(set_err), .hours_disp(hours_disp),
    .pm(pm), .minutes(minutes), .seconds(seconds), .sec_tick(sec_tick),
    .day_tick(day_tick), .pps_locked(pps_locked), .rows(rows), .cols(cols)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hours"}, hours_disp, 0);
    check({tag, "_min"}, minutes, 0);
    check({tag, "_sec"}, seconds, 0);
    check({tag, "_pm"}, pm, 0);
    check({tag, "_tick"}, {day_tick, sec_tick}, 0);
    check({tag, "_lock"}, pps_locked, 0);
    check({tag, "_set"}, {set_ready, set_err}, 0);
    check({tag, "_rows"}, rows, 0);
    check({tag, "_cols"}, cols, 0);
  endtask

  function automatic logic [3:0] exp_cols(input logic [3:0] r);
    // 13:45 in 12h: minutes=101101, hours_disp=00001, pm=1
    case (r)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b0110;
      4'b1011: return 4'b1000;
      4'b0111: return 4'b0000;
      default: return 4'b1111;
    endcase
  endfunction

  int tick_cnt, day_cnt, drop_n, quiet;
  logic [3:0] prev_rows, hot;

  initial begin
    rst_n = 1'b0; pps = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
    set_hours = '0; set_minutes = '0;
    repeat (3) step();
    check_reset_state("reset");

    // Free-run: one tick every 4 cycles, 240 ticks -> 00:04:00
    rst_n = 1'b1;
    tick_cnt = 0;
    for (int i = 0; i < 960; i++) begin
      step();
      if (i == 0) check("ready_after_reset", set_ready, 1);
      if (i < 8) check($sformatf("freerun_tick_%0d", i), sec_tick, ((i + 1) % 4 == 0));
      if (sec_tick) tick_cnt++;
    end
    check("freerun_tick_count", tick_cnt, 240);
    check("freerun_min", minutes, 4);
    check("freerun_sec", seconds, 0);

    // Set 23:59, run one minute across midnight
    set_valid = 1'b1; set_hours = 5'd23; set_minutes = 6'd59;
    step();
    set_valid = 1'b0;
    check("set_hours", hours_disp, 23);
    check("set_min", minutes, 59);
    check("set_sec", seconds, 0);
    check("set_ready_low", set_ready, 0);
    check("set_tick_none", sec_tick, 0);
    day_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (day_tick) day_cnt++;
      if (i == 239) check("day_tick_at_wrap", day_tick, 1);
    end
    check("day_tick_count", day_cnt, 1);
    check("midnight_time", {hours_disp, minutes, seconds}, 0);
    mode_12h = 1'b1;
    #1;
    check("midnight_12h", hours_disp, 12);
    check("midnight_pm", pm, 0);
    mode_12h = 1'b0;

    // Out-of-range set is rejected
    set_valid = 1'b1; set_hours = 5'd24; set_minutes = 6'd10;
    step();
    set_valid = 1'b0;
    check("bad_set_err", set_err, 1);
    check("bad_set_ready", set_ready, 0);
    check("bad_set_time", {hours_disp, minutes}, 0);
    step();
    check("bad_set_err_clear", set_err, 0);
    check("bad_set_ready_back", set_ready, 1);

    // PPS every 7 cycles: tick 3 edges after pps rises, only from PPS
    for (int k = 0; k < 4; k++) begin
      pps = 1'b1;
      for (int j = 1; j <= 7; j++) begin
        step();
        if (j == 2) pps = 1'b0;
        if (k > 0) check($sformatf("pps%0d_tick_j%0d", k, j), sec_tick, (j == 3));
        if (j == 3) check($sformatf("pps%0d_locked", k), pps_locked, 1);
      end
    end
    drop_n = 0;
    quiet = 0;
    for (int i = 1; i <= 40 && drop_n == 0; i++) begin
      step();
      if (sec_tick) quiet++;
      if (!pps_locked) drop_n = i;
    end
    check("lock_drop_cycles", drop_n, 16);
    check("locked_no_wrap_ticks", quiet, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("resume_tick_%0d", i), sec_tick, ((i + 1) % 4 == 0));
    end

    // Set 13:45, 12h mode, check scan rotation and row pixels
    set_valid = 1'b1; set_hours = 5'd13; set_minutes = 6'd45;
    step();
    set_valid = 1'b0;
    mode_12h = 1'b1;
    #1;
    check("pm_hours_disp", hours_disp, 1);
    check("pm_flag", pm, 1);
    check("pm_min", minutes, 45);
    repeat (3) step();
    prev_rows = rows;
    hot = ~prev_rows;
    check("scan_onehot", $countones(hot), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("scan_rows_%0d", i), rows, {prev_rows[2:0], prev_rows[3]});
      check($sformatf("scan_cols_r%b", rows), cols, exp_cols(rows));
      prev_rows = rows;
    end

    // Reset during a set request and a PPS in the synchroniser
    mode_12h = 1'b0;
    pps = 1'b1;
    step();
    rst_n = 1'b0; pps = 1'b0;
    set_valid = 1'b1; set_hours = 5'd5; set_minutes = 6'd5;
    step();
    check_reset_state("midrst");
    rst_n = 1'b1;
    set_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("midrst_nolock_%0d", i), pps_locked, 0);
    end
    check("midrst_time", {hours_disp, minutes}, 0);
    check("midrst_ready", set_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
